// File: rtl/rx_udp_pkg.sv
`default_nettype none
//==============================================================================
// Package     : rx_udp_pkg
// Description : Frame byte offsets, header constants and FSM encoding shared by
//               the UDP payload extractor.
// Revision    : 1.0 - initial release
//==============================================================================
package rx_udp_pkg;

    // Byte offsets counted from the first preamble byte.
    localparam logic [10:0] SFD_OFS   = 11'd7;
    localparam logic [10:0] DMAC_OFS  = 11'd8;
    localparam logic [10:0] ETYPE_OFS = 11'd20;
    localparam logic [10:0] IPVH_OFS  = 11'd22;
    localparam logic [10:0] PROTO_OFS = 11'd31;
    localparam logic [10:0] DIP_OFS   = 11'd38;
    localparam logic [10:0] ULEN_OFS  = 11'd46;
    localparam logic [10:0] PL_OFS    = 11'd50;
    localparam logic [10:0] B_MAX     = 11'd2047;

    localparam logic [7:0]  SFD_VAL     = 8'hD5;
    localparam logic [15:0] ETYPE_IPV4  = 16'h0800;
    localparam logic [7:0]  IPVH_45     = 8'h45;
    localparam logic [7:0]  PROTO_UDP   = 8'h11;
    localparam logic [15:0] UDP_HDR_LEN = 16'd8;
    localparam logic [47:0] BCAST_MAC   = 48'hFFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HDR     = 2'd1,
        PAYLOAD = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Big-endian byte selectors: index 0 is the byte sent first on the wire.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    return mac[47:40];
            3'd1:    return mac[39:32];
            3'd2:    return mac[31:24];
            3'd3:    return mac[23:16];
            3'd4:    return mac[15:8];
            default: return mac[7:0];
        endcase
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
        case (idx)
            2'd0:    return ip[31:24];
            2'd1:    return ip[23:16];
            2'd2:    return ip[15:8];
            default: return ip[7:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_hdr_match.sv
`default_nettype none
//==============================================================================
// Module      : rx_hdr_match
// Description : Byte-index addressed header comparator; latches per-field pass
//               flags and the UDP length while the header streams past.
// Revision    : 1.0 - initial release
//==============================================================================
module rx_hdr_match
    import rx_udp_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
    parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_00_02,
    parameter int          MAX_PL    = 1472
) (
    input  logic        sclk,
    input  logic        resetb,
    input  logic        frx_en,
    input  logic [7:0]  frx_data,
    input  logic [10:0] b,
    output logic        hdr_ok,
    output logic [15:0] pl_len
);

    localparam logic [15:0] c_ulen_min = 16'd9;
    localparam logic [15:0] c_ulen_max = 16'(MAX_PL) + UDP_HDR_LEN;

    logic        r_sfd_ok;
    logic        r_mac_loc;
    logic        r_mac_bc;
    logic        r_etype_ok;
    logic        r_ipvh_ok;
    logic        r_proto_ok;
    logic        r_dip_ok;
    logic [15:0] r_udp_len;

    logic        w_in_mac;
    logic        w_in_dip;
    logic [2:0]  w_mac_idx;
    logic [1:0]  w_dip_idx;

    assign w_in_mac  = (b >= DMAC_OFS) && (b < DMAC_OFS + 11'd6);
    assign w_mac_idx = 3'(b - DMAC_OFS);
    assign w_in_dip  = (b >= DIP_OFS) && (b < DIP_OFS + 11'd4);
    assign w_dip_idx = 2'(b - DIP_OFS);

    // Multi-byte fields start optimistic at byte 0 and are knocked out by any mismatch.
    always_ff @(posedge sclk) begin
        if (!resetb) begin
            r_sfd_ok   <= 1'b0;
            r_mac_loc  <= 1'b0;
            r_mac_bc   <= 1'b0;
            r_etype_ok <= 1'b0;
            r_ipvh_ok  <= 1'b0;
            r_proto_ok <= 1'b0;
            r_dip_ok   <= 1'b0;
            r_udp_len  <= '0;
        end else if (frx_en) begin
            if (b == 11'd0) begin
                r_sfd_ok   <= 1'b0;
                r_mac_loc  <= 1'b1;
                r_mac_bc   <= 1'b1;
                r_etype_ok <= 1'b1;
                r_ipvh_ok  <= 1'b0;
                r_proto_ok <= 1'b0;
                r_dip_ok   <= 1'b1;
                r_udp_len  <= '0;
            end
            if (b == SFD_OFS)
                r_sfd_ok <= (frx_data == SFD_VAL);
            if (w_in_mac) begin
                if (frx_data != mac_byte(LOCAL_MAC, w_mac_idx))
                    r_mac_loc <= 1'b0;
                if (frx_data != mac_byte(BCAST_MAC, w_mac_idx))
                    r_mac_bc <= 1'b0;
            end
            if ((b == ETYPE_OFS) && (frx_data != ETYPE_IPV4[15:8]))
                r_etype_ok <= 1'b0;
            if ((b == ETYPE_OFS + 11'd1) && (frx_data != ETYPE_IPV4[7:0]))
                r_etype_ok <= 1'b0;
            if (b == IPVH_OFS)
                r_ipvh_ok <= (frx_data == IPVH_45);
            if (b == PROTO_OFS)
                r_proto_ok <= (frx_data == PROTO_UDP);
            if (w_in_dip && (frx_data != ip_byte(LOCAL_IP, w_dip_idx)))
                r_dip_ok <= 1'b0;
            if (b == ULEN_OFS)
                r_udp_len[15:8] <= frx_data;
            if (b == ULEN_OFS + 11'd1)
                r_udp_len[7:0] <= frx_data;
        end
    end

    assign hdr_ok = r_sfd_ok && (r_mac_loc || r_mac_bc) && r_etype_ok && r_ipvh_ok
                 && r_proto_ok && r_dip_ok
                 && (r_udp_len >= c_ulen_min) && (r_udp_len <= c_ulen_max);
    assign pl_len = r_udp_len - UDP_HDR_LEN;

endmodule
`default_nettype wire

// File: rtl/rx_udp_payload_extract.sv
`default_nettype none
//==============================================================================
// Module      : rx_udp_payload_extract
// Description : Strips Ethernet/IPv4/UDP headers, padding and FCS from the
//               filtered RX byte stream and emits the framed UDP payload.
// Revision    : 1.0 - initial release
//==============================================================================
module rx_udp_payload_extract
    import rx_udp_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h00_0A_35_01_FE_C0,
    parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_00_02,
    parameter int          MAX_PL    = 1472
) (
    input  logic        sclk,
    input  logic        resetb,
    input  logic        frx_en,
    input  logic [7:0]  frx_data,
    output logic        pl_en,
    output logic [7:0]  pl_data,
    output logic        pl_sof,
    output logic        pl_eof,
    output logic [15:0] pl_len,
    output logic        pl_abort,
    output logic [15:0] pkt_ok_cnt,
    output logic [15:0] pkt_drop_cnt
);

    state_t      r_state;
    logic [10:0] r_b;
    logic        r_skip;
    logic [15:0] r_rem;
    logic        w_hdr_ok;
    logic [15:0] w_n;

    rx_hdr_match #(
        .LOCAL_MAC (LOCAL_MAC),
        .LOCAL_IP  (LOCAL_IP),
        .MAX_PL    (MAX_PL)
    ) u_hdr_match (
        .sclk     (sclk),
        .resetb   (resetb),
        .frx_en   (frx_en),
        .frx_data (frx_data),
        .b        (r_b),
        .hdr_ok   (w_hdr_ok),
        .pl_len   (w_n)
    );

    always_ff @(posedge sclk) begin
        if (!resetb) begin
            r_state      <= IDLE;
            r_b          <= '0;
            // A reset landing inside a burst must not be mistaken for a frame start.
            r_skip       <= frx_en;
            r_rem        <= '0;
            pl_en        <= 1'b0;
            pl_data      <= '0;
            pl_sof       <= 1'b0;
            pl_eof       <= 1'b0;
            pl_len       <= '0;
            pl_abort     <= 1'b0;
            pkt_ok_cnt   <= '0;
            pkt_drop_cnt <= '0;
        end else begin
            pl_en    <= 1'b0;
            pl_data  <= '0;
            pl_sof   <= 1'b0;
            pl_eof   <= 1'b0;
            pl_abort <= 1'b0;

            if (!frx_en) begin
                r_b    <= '0;
                r_skip <= 1'b0;
            end else if (r_b != B_MAX) begin
                r_b <= r_b + 11'd1;
            end

            case (r_state)
                IDLE: begin
                    if (frx_en && !r_skip)
                        r_state <= HDR;
                end
                HDR: begin
                    if (!frx_en) begin
                        r_state      <= IDLE;
                        pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
                    end else if (r_b == PL_OFS - 11'd1) begin
                        if (w_hdr_ok) begin
                            r_state <= PAYLOAD;
                            r_rem   <= w_n;
                        end else begin
                            r_state      <= DRAIN;
                            pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (!frx_en) begin
                        r_state      <= IDLE;
                        pl_abort     <= 1'b1;
                        pkt_drop_cnt <= pkt_drop_cnt + 16'd1;
                    end else begin
                        pl_en   <= 1'b1;
                        pl_data <= frx_data;
                        r_rem   <= r_rem - 16'd1;
                        if (r_b == PL_OFS) begin
                            pl_sof <= 1'b1;
                            pl_len <= r_rem;
                        end
                        if (r_rem == 16'd1) begin
                            pl_eof     <= 1'b1;
                            pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
                            r_state    <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!frx_en)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_udp_payload_extract.sv
`default_nettype none
//==============================================================================
// Module      : tb_rx_udp_payload_extract
// Description : Self-checking bench: directed vector table, hand-built corner
//               sequences and random frames against a frame-level model.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_rx_udp_payload_extract;

    localparam logic [47:0] LM     = 48'h000A_3501_FEC0;
    localparam logic [47:0] BC     = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] LI     = 32'hC0A8_0002;
    localparam int          MAX_PL = 1472;

    logic        sclk     = 1'b0;
    logic        resetb   = 1'b0;
    logic        frx_en   = 1'b0;
    logic [7:0]  frx_data = 8'h00;
    logic        pl_en;
    logic [7:0]  pl_data;
    logic        pl_sof;
    logic        pl_eof;
    logic [15:0] pl_len;
    logic        pl_abort;
    logic [15:0] pkt_ok_cnt;
    logic [15:0] pkt_drop_cnt;

    rx_udp_payload_extract #(
        .LOCAL_MAC (LM),
        .LOCAL_IP  (LI),
        .MAX_PL    (MAX_PL)
    ) dut (
        .sclk         (sclk),
        .resetb       (resetb),
        .frx_en       (frx_en),
        .frx_data     (frx_data),
        .pl_en        (pl_en),
        .pl_data      (pl_data),
        .pl_sof       (pl_sof),
        .pl_eof       (pl_eof),
        .pl_len       (pl_len),
        .pl_abort     (pl_abort),
        .pkt_ok_cnt   (pkt_ok_cnt),
        .pkt_drop_cnt (pkt_drop_cnt)
    );

    initial forever #5 sclk = ~sclk;

    typedef struct packed {
        logic [7:0] d;
        logic       sof;
        logic       eof;
    } obyte_t;

    typedef struct {
        logic [47:0] mac;
        logic [7:0]  sfd;
        logic [15:0] etype;
        logic [7:0]  ipvh;
        logic [7:0]  proto;
        logic [31:0] dip;
        logic [15:0] ulen;
        int          flen;
        logic [7:0]  seed;
        int          nout;
        int          plen;
        int          ok;
        int          drop;
        int          abrt;
    } vec_t;

    obyte_t      out_q[$];
    obyte_t      exp_q[$];
    logic [15:0] len_q[$];
    logic [15:0] exp_len_q[$];
    logic [7:0]  tx_q[$];
    int abort_cnt = 0, idle_viol = 0;
    int exp_ok = 0, exp_drop = 0, exp_abort = 0;
    int n_chk = 0, n_err = 0;

    always @(negedge sclk) begin
        if (pl_en) begin
            out_q.push_back('{d: pl_data, sof: pl_sof, eof: pl_eof});
            if (pl_sof) len_q.push_back(pl_len);
        end else if (pl_data != 8'h00 || pl_sof || pl_eof) begin
            idle_viol++;
        end
        if (pl_abort) abort_cnt++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic build(input logic [47:0] mac, input logic [7:0] sfd, input logic [15:0] etype,
                         input logic [7:0] ipvh, input logic [7:0] proto, input logic [31:0] dip,
                         input logic [15:0] ulen, input int flen, input logic [7:0] seed);
        logic [7:0] hb [50];
        for (int i = 0; i < 50; i++) hb[i] = 8'($urandom);
        for (int i = 0; i < 7; i++) hb[i] = 8'h55;
        hb[7] = sfd;
        for (int k = 0; k < 6; k++) hb[8 + k] = mac[47 - 8 * k -: 8];
        hb[20] = etype[15:8];
        hb[21] = etype[7:0];
        hb[22] = ipvh;
        hb[31] = proto;
        for (int k = 0; k < 4; k++) hb[38 + k] = dip[31 - 8 * k -: 8];
        hb[46] = ulen[15:8];
        hb[47] = ulen[7:0];
        tx_q.delete();
        for (int i = 0; i < flen; i++)
            tx_q.push_back(i < 50 ? hb[i] : 8'(seed + 8'(i - 50)));
    endtask

    task automatic drive(input int gap, input int rst_at);
        for (int i = 0; i < tx_q.size(); i++) begin
            frx_en   = 1'b1;
            frx_data = tx_q[i];
            if (i == rst_at) resetb = 1'b0;
            @(posedge sclk);
            #1;
            if (i == rst_at) begin
                resetb = 1'b1;
                chk("rst_mid_pl_en", int'(pl_en), 0);
                chk("rst_mid_ok_cnt", int'(pkt_ok_cnt), 0);
                chk("rst_mid_drop_cnt", int'(pkt_drop_cnt), 0);
            end
        end
        frx_en   = 1'b0;
        frx_data = 8'h00;
        repeat (gap) begin
            @(posedge sclk);
            #1;
        end
    endtask

    // Hand-stated expectation for the frame currently in tx_q.
    task automatic expect_fixed(input int nout, input int plen, input int ok, input int drop, input int abrt);
        obyte_t e;
        for (int i = 0; i < nout; i++) begin
            e.d   = tx_q[50 + i];
            e.sof = (i == 0);
            e.eof = (ok != 0) && (i == nout - 1);
            exp_q.push_back(e);
        end
        if (nout > 0) exp_len_q.push_back(16'(plen));
        exp_ok    += ok;
        exp_drop  += drop;
        exp_abort += abrt;
    endtask

    // Frame-level reference: decide accept/drop from the raw bytes, then slice the payload.
    task automatic model();
        int len, u, n, avail, k;
        logic pass;
        obyte_t e;
        len = tx_q.size();
        if (len < 50) begin
            exp_drop++;
            return;
        end
        u = int'({tx_q[46], tx_q[47]});
        pass = (tx_q[7] == 8'hD5)
            && (({tx_q[8], tx_q[9], tx_q[10], tx_q[11], tx_q[12], tx_q[13]} == LM)
             || ({tx_q[8], tx_q[9], tx_q[10], tx_q[11], tx_q[12], tx_q[13]} == BC))
            && ({tx_q[20], tx_q[21]} == 16'h0800) && (tx_q[22] == 8'h45) && (tx_q[31] == 8'h11)
            && ({tx_q[38], tx_q[39], tx_q[40], tx_q[41]} == LI)
            && (u >= 9) && (u <= MAX_PL + 8);
        if (!pass) begin
            exp_drop++;
            return;
        end
        n     = u - 8;
        avail = len - 50;
        k     = (avail < n) ? avail : n;
        for (int i = 0; i < k; i++) begin
            e.d   = tx_q[50 + i];
            e.sof = (i == 0);
            e.eof = (avail >= n) && (i == n - 1);
            exp_q.push_back(e);
        end
        if (k > 0) exp_len_q.push_back(16'(n));
        if (avail >= n) exp_ok++;
        else begin
            exp_abort++;
            exp_drop++;
        end
    endtask

    task automatic check_all(input string tag);
        int bad;
        chk({tag, "_count"}, out_q.size(), exp_q.size());
        bad = -1;
        for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
            if (bad < 0 && out_q[i] != exp_q[i]) bad = i;
        n_chk++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s_seq[%0d]: got d=%h sof=%b eof=%b expected d=%h sof=%b eof=%b", tag, bad,
                     out_q[bad].d, out_q[bad].sof, out_q[bad].eof, exp_q[bad].d, exp_q[bad].sof, exp_q[bad].eof);
        end
        bad = (len_q.size() != exp_len_q.size()) ? 0 : -1;
        for (int i = 0; bad < 0 && i < len_q.size(); i++)
            if (len_q[i] != exp_len_q[i]) bad = i;
        n_chk++;
        if (bad >= 0) begin
            n_err++;
            $display("FAIL %s_pl_len: got %0d lens (first %0d) expected %0d lens (first %0d)", tag,
                     len_q.size(), (len_q.size() > bad) ? int'(len_q[bad]) : -1,
                     exp_len_q.size(), (exp_len_q.size() > bad) ? int'(exp_len_q[bad]) : -1);
        end
        chk({tag, "_abort"}, abort_cnt, exp_abort);
        chk({tag, "_ok_cnt"}, int'(pkt_ok_cnt), exp_ok & 16'hFFFF);
        chk({tag, "_drop_cnt"}, int'(pkt_drop_cnt), exp_drop & 16'hFFFF);
        chk({tag, "_idle_clean"}, idle_viol, 0);
        out_q.delete();
        exp_q.delete();
        len_q.delete();
        exp_len_q.delete();
    endtask

    vec_t vt [15];

    initial begin
        logic [47:0] rmac;
        logic [15:0] rulen;
        int rn, rflen;

        vt[0]  = '{LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd16, 72, 8'h01, 8, 8, 1, 0, 0};
        vt[1]  = '{LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd9, 72, 8'hAA, 1, 1, 1, 0, 0};
        vt[2]  = '{BC, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd12, 72, 8'h30, 4, 4, 1, 0, 0};
        vt[3]  = '{LM, 8'hD5, 16'h0800, 8'h45, 8'h11, 32'hC0A80003, 16'd16, 72, 8'h01, 0, 0, 0, 1, 0};
        vt[4]  = '{LM, 8'hD5, 16'h0806, 8'h45, 8'h11, LI, 16'd16, 72, 8'h01, 0, 0, 0, 1, 0};
        vt[5]  = '{LM, 8'hD5, 16'h0800, 8'h45, 8'h06, LI, 16'd16, 72, 8'h01, 0, 0, 0, 1, 0};
        vt[6]  = '{LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd8, 72, 8'h01, 0, 0, 0, 1, 0};
        vt[7]  = '{LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd1481, 72, 8'h01, 0, 0, 0, 1, 0};
        vt[8]  = '{LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd1480, 1526, 8'h00, 1472, 1472, 1, 0, 0};
        vt[9]  = '{48'h000A_3501_FEC1, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd16, 72, 8'h01, 0, 0, 0, 1, 0};
        vt[10] = '{LM, 8'hD4, 16'h0800, 8'h45, 8'h11, LI, 16'd16, 72, 8'h01, 0, 0, 0, 1, 0};
        vt[11] = '{LM, 8'hD5, 16'h0800, 8'h46, 8'h11, LI, 16'd16, 72, 8'h01, 0, 0, 0, 1, 0};
        vt[12] = '{LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd16, 30, 8'h01, 0, 0, 0, 1, 0};
        vt[13] = '{LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd58, 100, 8'h10, 50, 50, 1, 0, 0};
        vt[14] = '{LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd16, 50, 8'h01, 0, 0, 0, 1, 1};

        resetb = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        chk("rst_outputs", int'({pl_en, pl_sof, pl_eof, pl_abort, pl_data, pl_len}), 0);
        chk("rst_ok_cnt", int'(pkt_ok_cnt), 0);
        chk("rst_drop_cnt", int'(pkt_drop_cnt), 0);
        resetb = 1'b1;
        @(posedge sclk);
        #1;

        for (int r = 0; r < 15; r++) begin
            build(vt[r].mac, vt[r].sfd, vt[r].etype, vt[r].ipvh, vt[r].proto, vt[r].dip,
                  vt[r].ulen, vt[r].flen, vt[r].seed);
            expect_fixed(vt[r].nout, vt[r].plen, vt[r].ok, vt[r].drop, vt[r].abrt);
            drive(4, -1);
            check_all($sformatf("vec%0d", r));
        end

        // Truncated after 3 of 10 payload bytes, then a good frame after one idle cycle.
        build(LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd18, 53, 8'h40);
        expect_fixed(3, 10, 0, 1, 1);
        drive(1, -1);
        build(LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd16, 72, 8'h60);
        expect_fixed(8, 8, 1, 0, 0);
        drive(4, -1);
        check_all("b2b");

        // Reset on the sixth payload byte: five bytes out, counters restart.
        build(LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd20, 76, 8'h80);
        expect_fixed(5, 12, 0, 0, 0);
        drive(4, 55);
        exp_ok   = 0;
        exp_drop = 0;
        check_all("rst_mid");
        build(LM, 8'hD5, 16'h0800, 8'h45, 8'h11, LI, 16'd16, 72, 8'h90);
        expect_fixed(8, 8, 1, 0, 0);
        drive(4, -1);
        check_all("post_rst");

        for (int g = 0; g < 5; g++) begin
            for (int f = 0; f < 8; f++) begin
                case ($urandom_range(0, 9))
                    0, 1, 2, 3, 4, 5: rmac = LM;
                    6, 7:             rmac = BC;
                    default:          rmac = LM ^ (48'd1 << $urandom_range(0, 47));
                endcase
                case ($urandom_range(0, 9))
                    0:       rulen = 16'($urandom_range(0, 12));
                    1:       rulen = 16'($urandom_range(MAX_PL + 6, MAX_PL + 10));
                    default: rulen = 16'($urandom_range(9, 80));
                endcase
                rn = (int'(rulen) > 8) ? int'(rulen) - 8 : 1;
                if ($urandom_range(0, 4) == 0) rflen = $urandom_range(30, 50 + rn);
                else                            rflen = 50 + rn + $urandom_range(0, 20);
                build(rmac,
                      ($urandom_range(0, 9) == 0) ? 8'hD4 : 8'hD5,
                      ($urandom_range(0, 9) == 0) ? 16'h0806 : 16'h0800,
                      ($urandom_range(0, 9) == 0) ? 8'h44 : 8'h45,
                      ($urandom_range(0, 9) == 0) ? 8'h06 : 8'h11,
                      ($urandom_range(0, 9) == 0) ? (LI ^ 32'd1) : LI,
                      rulen, rflen, 8'($urandom));
                model();
                drive($urandom_range(1, 3), -1);
            end
            repeat (4) begin
                @(posedge sclk);
                #1;
            end
            check_all($sformatf("rand%0d", g));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
